// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard scoreboard, writeback sequencing
// and R15 pixel-port arbitration for the register bank.
module decode_hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [3:0]       id_rp,
  input  logic [3:0]       id_rs,
  input  logic             id_rd_a,
  input  logic             id_rd_b,
  input  logic             id_a_r14,
  input  logic             id_b_r15,
  input  logic             id_wr,
  input  logic [3:0]       id_rg,
  input  logic             id_link,
  input  logic             ex_flush,
  input  logic             pix_req,
  output logic             sel_A,
  output logic             sel_B,
  output logic             sel_C,
  output logic             WE_C,
  output logic             WE_V,
  output logic             pix_ack,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic       v;
    logic [3:0] dst;
    logic       link;
  } sb_t;

  sb_t              sb_q [DEPTH];
  sb_t              sb_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic [3:0] dst;
  logic [3:0] src_a;
  logic [3:0] src_b;
  logic       m_a;
  logic       m_b;
  logic       m_15;
  logic       hazard;
  logic       issue;

  assign dst   = id_link ? 4'd14 : id_rg;
  assign src_a = id_a_r14 ? 4'd14 : id_rp;
  assign src_b = id_b_r15 ? 4'd15 : id_rs;

  // WB entry counts too: bank write and read share an edge, no bypass
  always_comb begin
    m_a  = 1'b0;
    m_b  = 1'b0;
    m_15 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_a  = m_a  | (sb_q[i].v & (sb_q[i].dst == src_a));
      m_b  = m_b  | (sb_q[i].v & (sb_q[i].dst == src_b));
      m_15 = m_15 | (sb_q[i].v & (sb_q[i].dst == 4'd15));
    end
  end

  assign hazard = id_valid & ((id_rd_a & m_a) | (id_rd_b & m_b));
  assign stall  = hazard & ~ex_flush;
  assign issue  = id_valid & ~hazard & ~ex_flush;

  assign sel_A = id_a_r14;
  assign sel_B = id_b_r15;
  assign WE_C  = sb_q[DEPTH-1].v;
  assign sel_C = sb_q[DEPTH-1].link;

  assign pix_ack = pix_req & ~m_15
                 & ~(issue & id_wr & (dst == 4'd15));
  assign WE_V    = pix_ack;

  assign stall_cnt = cnt_q;

  always_comb begin
    sb_d = '0;
    if (issue) begin
      sb_d.v    = id_wr;
      sb_d.dst  = dst;
      sb_d.link = id_link;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sb_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      sb_q[0] <= sb_d;
      for (int i = 1; i < DEPTH; i++) sb_q[i] <= sb_q[i-1];
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// Directed bench for decode_hazard_ctrl: hazards, writeback,
// link, pixel arbitration, flush and async reset.
module tb_decode_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_rd_a, id_rd_b, id_a_r14, id_b_r15;
  logic        id_wr, id_link, ex_flush, pix_req;
  logic [3:0]  id_rp, id_rs, id_rg;
  logic        sel_A, sel_B, sel_C, WE_C, WE_V, pix_ack, stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  decode_hazard_ctrl #(.DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rp(id_rp), .id_rs(id_rs),
    .id_rd_a(id_rd_a), .id_rd_b(id_rd_b),
    .id_a_r14(id_a_r14), .id_b_r15(id_b_r15),
    .id_wr(id_wr), .id_rg(id_rg), .id_link(id_link),
    .ex_flush(ex_flush), .pix_req(pix_req),
    .sel_A(sel_A), .sel_B(sel_B), .sel_C(sel_C),
    .WE_C(WE_C), .WE_V(WE_V), .pix_ack(pix_ack),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  task automatic idle();
    id_valid = 0; id_rd_a = 0; id_rd_b = 0;
    id_a_r14 = 0; id_b_r15 = 0; id_wr = 0;
    id_link = 0; ex_flush = 0; pix_req = 0;
    id_rp = 0; id_rs = 0; id_rg = 0;
  endtask

  // advance to just after the next rising edge
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_wr(input logic [3:0] rg);
    idle();
    id_valid = 1; id_wr = 1; id_rg = rg;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 0;
    #12;
    checks++;
    if ({WE_C, sel_C, stall, WE_V} !== 4'b0000)
      $display("FAIL reset_outs got=%b exp=0000",
               {WE_C, sel_C, stall, WE_V});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0)
      $display("FAIL reset_cnt got=%0d exp=0", stall_cnt);
    else passed++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_raw();
    next(); issue_wr(4'd3);
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) $display("FAIL raw_c0 stall=%b exp=0", stall);
    else passed++;
    for (int i = 1; i <= 4; i++) begin
      next();
      idle(); id_valid = 1; id_rd_a = 1; id_rp = 4'd3;
      @(negedge clk);
      checks++;
      if (stall !== (i <= 3))
        $display("FAIL raw_stall c%0d got=%b exp=%b", i, stall, i <= 3);
      else passed++;
      checks++;
      if (WE_C !== (i == 3))
        $display("FAIL raw_wec c%0d got=%b exp=%b", i, WE_C, i == 3);
      else passed++;
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd3)
      $display("FAIL raw_cnt got=%0d exp=3", stall_cnt);
    else passed++;
  endtask

  task automatic test_independent();
    logic [5:0] exp_we;
    exp_we = 6'b011000;
    for (int i = 0; i < 6; i++) begin
      next(); idle();
      if (i == 0) begin
        id_valid = 1; id_rd_a = 1; id_rp = 4'd1;
        id_wr = 1; id_rg = 4'd2;
      end else if (i == 1) begin
        id_valid = 1; id_rd_a = 1; id_rp = 4'd4;
        id_wr = 1; id_rg = 4'd5;
      end
      @(negedge clk);
      checks++;
      if ({stall, WE_C, sel_C} !== {1'b0, exp_we[i], 1'b0})
        $display("FAIL indep c%0d stall/we/selc=%b exp=%b", i,
                 {stall, WE_C, sel_C}, {1'b0, exp_we[i], 1'b0});
      else passed++;
    end
  endtask

  task automatic test_link();
    next(); idle();
    id_valid = 1; id_wr = 1; id_link = 1; id_rg = 4'd7;
    for (int i = 1; i <= 4; i++) begin
      next(); idle();
      id_valid = 1; id_rd_a = 1; id_a_r14 = 1; id_rp = 4'd0;
      @(negedge clk);
      checks++;
      if ({sel_A, stall} !== {1'b1, i <= 3})
        $display("FAIL link_stall c%0d selA/stall=%b exp=%b", i,
                 {sel_A, stall}, {1'b1, i <= 3});
      else passed++;
      checks++;
      if ({WE_C, sel_C} !== {i == 3, i == 3})
        $display("FAIL link_wb c%0d we/selc=%b exp=%b", i,
                 {WE_C, sel_C}, {i == 3, i == 3});
      else passed++;
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd6)
      $display("FAIL link_cnt got=%0d exp=6", stall_cnt);
    else passed++;
  endtask

  task automatic test_dual();
    next(); issue_wr(4'd2);
    next(); issue_wr(4'd8);
    for (int i = 2; i <= 5; i++) begin
      next(); idle();
      id_valid = 1; id_rd_a = 1; id_rp = 4'd2;
      id_rd_b = 1; id_rs = 4'd8;
      @(negedge clk);
      checks++;
      if (stall !== (i <= 4))
        $display("FAIL dual c%0d stall=%b exp=%b", i, stall, i <= 4);
      else passed++;
    end
    next(); idle();
    @(negedge clk);
    checks++;
    if (stall_cnt !== 16'd9)
      $display("FAIL dual_cnt got=%0d exp=9", stall_cnt);
    else passed++;
  endtask

  task automatic test_pixel();
    logic [5:0] exp_ack;
    exp_ack = 6'b110000;
    next(); issue_wr(4'd15); pix_req = 1;
    @(negedge clk);
    checks++;
    if (pix_ack !== 1'b0)
      $display("FAIL pix c0 ack=%b exp=0", pix_ack);
    else passed++;
    for (int i = 1; i <= 5; i++) begin
      next(); idle(); pix_req = 1;
      if (i == 5) id_b_r15 = 1;
      @(negedge clk);
      checks++;
      if ({pix_ack, WE_V} !== {2{exp_ack[i]}})
        $display("FAIL pix c%0d ack/wev=%b exp=%b", i,
                 {pix_ack, WE_V}, {2{exp_ack[i]}});
      else passed++;
    end
    checks++;
    if ({sel_B, stall} !== 2'b10)
      $display("FAIL selB selB/stall=%b exp=10", {sel_B, stall});
    else passed++;
    next(); idle();
  endtask

  task automatic test_flush();
    next(); issue_wr(4'd6);
    next(); idle();
    id_valid = 1; id_rd_b = 1; id_rs = 4'd6;
    id_wr = 1; id_rg = 4'd9; ex_flush = 1;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) $display("FAIL flush_stall got=%b exp=0", stall);
    else passed++;
    for (int i = 2; i <= 5; i++) begin
      next(); idle();
      @(negedge clk);
      checks++;
      if (WE_C !== (i == 3))
        $display("FAIL flush_wec c%0d got=%b exp=%b", i, WE_C, i == 3);
      else passed++;
    end
    checks++;
    if (stall_cnt !== 16'd9)
      $display("FAIL flush_cnt got=%0d exp=9", stall_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid_stall();
    next(); issue_wr(4'd1);
    next(); issue_wr(4'd2);
    next(); issue_wr(4'd3);
    next(); idle(); id_valid = 1; id_rd_a = 1; id_rp = 4'd1;
    @(negedge clk);
    checks++;
    if ({stall, WE_C} !== 2'b11)
      $display("FAIL rst_pre stall/we=%b exp=11", {stall, WE_C});
    else passed++;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({WE_C, sel_C, stall} !== 3'b000)
      $display("FAIL rst_async we/selc/stall=%b exp=000",
               {WE_C, sel_C, stall});
    else passed++;
    checks++;
    if (stall_cnt !== 16'd0)
      $display("FAIL rst_async_cnt got=%0d exp=0", stall_cnt);
    else passed++;
    idle();
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      next();
      @(negedge clk);
      checks++;
      if (WE_C !== 1'b0)
        $display("FAIL rst_stale c%0d WE_C=%b exp=0", i, WE_C);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_independent();
    test_link();
    test_dual();
    test_pixel();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
